c1541_track_ctrl: RTL
=====================

Name: c1541_track_ctrl

Overview:
Sequences the 1541 GCR track buffer (8 KiB, 32 slots of 256 bytes) against the SD block interface. On a head move, image mount or flush request it writes back the old track if dirty, then loads the new track one 256-byte sector per SD request. It drives `busy` to the GCR block while the buffer is being transferred. It sits between the drive logic (track, write strobe) and the host SD block handshake.

Parameters:
SETTLE_CYCLES, 16'd2000, clk cycles `track` must be stable before a load starts.
MAX_TRACK, 6'd40, highest accepted track number; larger values are clamped to it.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
track  in  6  requested track number (1-based); 0 is treated as 1
we  in  1  buffer write strobe from the GCR block; marks the buffer dirty
flush  in  1  single-cycle request to write back a dirty buffer without moving
img_mounted  in  1  single-cycle pulse when a new image is mounted
img_readonly  in  1  image is read-only
sd_ack  in  1  host acknowledge; high while a block transfer is in progress
sd_lba  out  32  256-byte block address for the current request
sd_rd  out  1  block read request
sd_wr  out  1  block write request
buf_sector  out  5  buffer slot for the current transfer (drives buffer address bits [12:8])
busy  out  1  buffer is being transferred; the GCR block must idle
cur_track  out  6  track currently held in the buffer (0 = none)
dirty  out  1  buffer differs from the image

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, buf_sector=0, busy=1, cur_track=0, dirty=0, state=SETTLE with the settle counter cleared.
- Sectors per track:
  - tracks 1-17: 21
  - tracks 18-24: 19
  - tracks 25-30: 18
  - tracks 31-40: 17
- Track start LBA = sum of the sector counts of all lower tracks. Examples: T1=0, T18=357, T25=490, T31=598, T36=683.
- Request LBA = start LBA + buf_sector.
- States:
  - IDLE: busy=0.
    - `img_mounted` -> cur_track:=0, dirty:=0, go to SETTLE.
    - `track` differs from cur_track -> SETTLE.
    - `flush` with dirty=1 -> WR_REQ for cur_track, followed by IDLE.
  - SETTLE: busy=1; counter increments each cycle and restarts whenever `track` changes.
    - On reaching SETTLE_CYCLES-1 with dirty=1 and cur_track!=0 -> WR_REQ.
    - Otherwise -> RD_REQ.
    - In either case buf_sector:=0.
  - WR_REQ: sd_wr=1 and sd_lba valid, held until sd_ack=1 -> WR_WAIT.
  - WR_WAIT: waits for sd_ack=0.
    - Last sector -> dirty:=0, buf_sector:=0, then IDLE (flush case) or RD_REQ (track change case).
    - Otherwise buf_sector+1 -> WR_REQ.
  - RD_REQ / RD_WAIT: same handshake using sd_rd, addressed with the latched target track.
    - After the last sector: cur_track:=target, then IDLE.
- Handshake rules:
  - Only one of sd_rd/sd_wr is ever high.
  - A request is deasserted in the cycle after sd_ack is seen high.
  - A new request is never raised while sd_ack=1.
- `we`:
  - Sets dirty in any cycle where busy=0 and img_readonly=0.
  - Ignored while busy=1 or when img_readonly=1.
- A track change during a read is not acted on until the current sector completes; the block then returns to SETTLE (the partial load is abandoned, cur_track:=0).
- A write-back always runs to completion, regardless of track changes.
- `img_mounted` during a transfer: the current sector completes, then cur_track:=0, dirty:=0, SETTLE (no write-back to the new image).
- `flush` while busy, or while dirty=0: ignored.
- Track clamp: 0 is treated as 1; values above MAX_TRACK are treated as MAX_TRACK.
- Reset mid-operation: all outputs return to their reset values immediately, and the dirty data is lost.

Decomposition:
- Shared package `c1541_pkg`: state enum, sector-count function, track start-LBA function, MAX_SECTORS=21 constant.
- One sub-module, `c1541_track_lba`: combinational track -> {sector_count, start_lba} using a 40-entry constant table.

Test Plan:
- Reset, then track=18 held for SETTLE_CYCLES -> 19 reads at LBA 357..375, buf_sector 0..18, then cur_track=18, busy=0.
- Pulse we (dirty=1), change track to 25 -> 19 writes at LBA 357..375, then 18 reads at LBA 490..507, then dirty=0.
- track toggles 1->2->1 faster than SETTLE_CYCLES -> no request issued until stable; then load LBA 0..20.
- Read-only image: we pulses, then track to 31 -> no sd_wr ever asserted; reads at LBA 598..614.
- img_mounted during read of sector 5 -> sector 5 handshake completes; cur_track=0, dirty=0; track reloads from sector 0.
- flush with dirty=1 on track 36 -> writes at LBA 683..699, then IDLE, cur_track stays 36; assert reset_n low mid-write -> sd_wr=0 asynchronously.

Source files
------------

// File: rtl/c1541_track_ctrl_pkg.sv
// Shared types and track geometry helpers for the 1541 track buffer sequencer.
// Zone layout: 21/19/18/17 sectors per track.
package c1541_pkg;

  localparam int MAX_SECTORS = 21;
  localparam int SEC_W = $clog2(MAX_SECTORS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } state_t;

  function automatic logic [5:0] clamp_track(
    input logic [5:0] t,
    input logic [5:0] mx
  );
    if (t == 6'd0) return 6'd1;
    if (t > mx) return mx;
    return t;
  endfunction

  function automatic logic [4:0] track_sectors(input logic [5:0] t);
    if (t <= 6'd17) return 5'd21;
    if (t <= 6'd24) return 5'd19;
    if (t <= 6'd30) return 5'd18;
    return 5'd17;
  endfunction

  function automatic logic [9:0] track_start(input logic [5:0] t);
    int n;
    int v;
    n = (t == 6'd0) ? 1 : int'(t);
    if (n <= 18) v = (n - 1) * 21;
    else if (n <= 25) v = 357 + (n - 18) * 19;
    else if (n <= 31) v = 490 + (n - 25) * 18;
    else v = 598 + (n - 31) * 17;
    return v[9:0];
  endfunction

endpackage

// File: rtl/c1541_track_ctrl_if.sv
// SD block handshake between the track sequencer and the host.
// Carries the block address and the buffer slot being moved.
interface c1541_track_ctrl_if
  import c1541_pkg::*;
();
  logic [31:0]      sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;
  logic [SEC_W-1:0] buf_sector;

  modport master (
    output sd_lba, sd_rd, sd_wr, buf_sector,
    input  sd_ack
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, buf_sector,
    output sd_ack
  );
endinterface

// File: rtl/c1541_track_lba.sv
// Track number to sector count and first block address.
// Backed by a 40-entry constant table.
module c1541_track_lba
  import c1541_pkg::*;
(
  input  logic [5:0] track,
  output logic [4:0] sector_count,
  output logic [9:0] start_lba
);

  logic [9:0] lba_tab [40];
  logic [4:0] cnt_tab [40];
  logic [5:0] idx;

  for (genvar i = 0; i < 40; i++) begin : g_tab
    assign lba_tab[i] = track_start(6'(i + 1));
    assign cnt_tab[i] = track_sectors(6'(i + 1));
  end

  assign idx = (track == 6'd0)  ? 6'd0  :
               (track > 6'd40)  ? 6'd39 :
               track - 6'd1;

  assign sector_count = cnt_tab[idx];
  assign start_lba    = lba_tab[idx];

endmodule

// File: rtl/c1541_track_ctrl.sv
// Moves the GCR track buffer to/from the SD image one sector at a time.
// Writes back a dirty track before loading a new one.
module c1541_track_ctrl
  import c1541_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd2000,
  parameter logic [5:0]  MAX_TRACK     = 6'd40
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          track,
  input  logic                we,
  input  logic                flush,
  input  logic                img_mounted,
  input  logic                img_readonly,
  c1541_track_ctrl_if.master  sd,
  output logic                busy,
  output logic [5:0]          cur_track,
  output logic                dirty
);

  state_t      state;
  logic [15:0] cnt;
  logic [5:0]  trk_c;
  logic [5:0]  trk_q;
  logic [5:0]  target;
  logic [5:0]  new_trk;
  logic        flush_mode;
  logic        mount_pend;
  logic [4:0]  sec_nx;
  logic [4:0]  cur_cnt;
  logic [4:0]  new_cnt;
  logic [9:0]  cur_start;
  logic [9:0]  new_start;

  assign trk_c   = clamp_track(track, MAX_TRACK);
  assign new_trk = (state == ST_SETTLE) ? trk_c : target;
  assign sec_nx  = sd.buf_sector + 5'd1;

  c1541_track_lba u_lba_cur (
    .track        (cur_track),
    .sector_count (cur_cnt),
    .start_lba    (cur_start)
  );

  c1541_track_lba u_lba_new (
    .track        (new_trk),
    .sector_count (new_cnt),
    .start_lba    (new_start)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_SETTLE;
      cnt           <= '0;
      trk_q         <= '0;
      target        <= '0;
      flush_mode    <= 1'b0;
      mount_pend    <= 1'b0;
      sd.sd_lba     <= '0;
      sd.sd_rd      <= 1'b0;
      sd.sd_wr      <= 1'b0;
      sd.buf_sector <= '0;
      busy          <= 1'b1;
      cur_track     <= '0;
      dirty         <= 1'b0;
    end else begin
      trk_q <= trk_c;
      unique case (state)
        ST_IDLE: begin
          if (img_mounted) begin
            cur_track <= '0;
            dirty     <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= ST_SETTLE;
          end else begin
            if (we && !img_readonly) dirty <= 1'b1;
            if (trk_c != cur_track) begin
              busy  <= 1'b1;
              cnt   <= '0;
              state <= ST_SETTLE;
            end else if (flush && dirty) begin
              busy          <= 1'b1;
              flush_mode    <= 1'b1;
              sd.buf_sector <= '0;
              sd.sd_wr      <= 1'b1;
              sd.sd_lba     <= 32'(cur_start);
              state         <= ST_WR_REQ;
            end
          end
        end
        ST_SETTLE: begin
          if (img_mounted) begin
            cur_track <= '0;
            dirty     <= 1'b0;
            cnt       <= '0;
          end else if (trk_c != trk_q) begin
            cnt <= '0;
          end else if (cnt == SETTLE_CYCLES - 16'd1) begin
            target        <= trk_c;
            sd.buf_sector <= '0;
            flush_mode    <= 1'b0;
            cnt           <= '0;
            if (dirty && cur_track != 6'd0) begin
              sd.sd_wr  <= 1'b1;
              sd.sd_lba <= 32'(cur_start);
              state     <= ST_WR_REQ;
            end else begin
              sd.sd_rd  <= 1'b1;
              sd.sd_lba <= 32'(new_start);
              state     <= ST_RD_REQ;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WR_REQ: begin
          if (img_mounted) mount_pend <= 1'b1;
          if (sd.sd_ack) begin
            sd.sd_wr <= 1'b0;
            state    <= ST_WR_WAIT;
          end
        end
        ST_RD_REQ: begin
          if (img_mounted) mount_pend <= 1'b1;
          if (sd.sd_ack) begin
            sd.sd_rd <= 1'b0;
            state    <= ST_RD_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (img_mounted) mount_pend <= 1'b1;
          if (!sd.sd_ack) begin
            // A new image must never receive the old image's data
            if (mount_pend || img_mounted) begin
              mount_pend <= 1'b0;
              cur_track  <= '0;
              dirty      <= 1'b0;
              cnt        <= '0;
              state      <= ST_SETTLE;
            end else if (sd.buf_sector == cur_cnt - 5'd1) begin
              dirty         <= 1'b0;
              sd.buf_sector <= '0;
              if (flush_mode) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                sd.sd_rd  <= 1'b1;
                sd.sd_lba <= 32'(new_start);
                state     <= ST_RD_REQ;
              end
            end else begin
              sd.buf_sector <= sec_nx;
              sd.sd_wr      <= 1'b1;
              sd.sd_lba     <= 32'(cur_start + {5'd0, sec_nx});
              state         <= ST_WR_REQ;
            end
          end
        end
        ST_RD_WAIT: begin
          if (img_mounted) mount_pend <= 1'b1;
          if (!sd.sd_ack) begin
            if (mount_pend || img_mounted) begin
              mount_pend <= 1'b0;
              cur_track  <= '0;
              dirty      <= 1'b0;
              cnt        <= '0;
              state      <= ST_SETTLE;
            end else if (trk_c != target) begin
              cur_track <= '0;
              cnt       <= '0;
              state     <= ST_SETTLE;
            end else if (sd.buf_sector == new_cnt - 5'd1) begin
              cur_track <= target;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              sd.buf_sector <= sec_nx;
              sd.sd_rd      <= 1'b1;
              sd.sd_lba     <= 32'(new_start + {5'd0, sec_nx});
              state         <= ST_RD_REQ;
            end
          end
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end

endmodule
